// File: rtl/mips_div_pkg.sv
// Shared types and sizing for the EX-stage radix-2 restoring divider.
package mips_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// try to subtract the divisor magnitude, keep the result if it did not borrow.
module div_step
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             nextBit,
  input  logic [WIDTH-1:0] divisorMag,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The trial is only WIDTH+1 bits, so its sign bit is meaningful only while the
  // shifted remainder is below 2^WIDTH; once remIn's MSB is set the shifted value
  // already exceeds any divisor and the subtraction must succeed.
  always_comb begin
    shifted = {remIn, nextBit};
    trial   = shifted - {1'b0, divisorMag};
    qBit    = remIn[WIDTH-1] | ~trial[WIDTH];
    remOut  = qBit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider for the EX stage (quotient -> LO,
// remainder -> HI). Define DIV_EARLY_OUT_EN to skip CALC for trivial operands.
module div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall_div,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t state;
  logic [CW-1:0] counter;
  logic [WIDTH-1:0] partRem;
  logic [WIDTH-1:0] workQ;
  logic [WIDTH-1:0] divisorMag;
  logic signQ;
  logic signR;

  logic dividendNeg;
  logic divisorNeg;
  logic [WIDTH-1:0] dividendAbs;
  logic [WIDTH-1:0] divisorAbs;
  logic [WIDTH-1:0] stepRem;
  logic stepQ;
  logic [WIDTH-1:0] finalQ;

  // workQ starts as |dividend| and fills with quotient bits from the right as the
  // dividend bits are shifted out of its top.
  always_comb begin
    dividendNeg = signed_div & dividend[WIDTH-1];
    divisorNeg  = signed_div & divisor[WIDTH-1];
    dividendAbs = dividendNeg ? -dividend : dividend;
    divisorAbs  = divisorNeg ? -divisor : divisor;
    finalQ      = {workQ[WIDTH-2:0], stepQ};
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .remIn(partRem),
    .nextBit(workQ[WIDTH-1]),
    .divisorMag(divisorMag),
    .remOut(stepRem),
    .qBit(stepQ)
  );

`ifdef DIV_EARLY_OUT_EN
  logic earlyOut;
  logic [WIDTH-1:0] earlyQ;

  always_comb begin
    earlyOut = (divisorAbs == '0) || (dividendAbs < divisorAbs);
    earlyQ   = (divisorAbs == '0) ? '1 : '0;
    if (dividendNeg ^ divisorNeg) earlyQ = -earlyQ;
  end
`endif

  assign stall_div = ((state == IDLE) && start && !cancel) || (state == CALC);

  // Cancel wins in every state and leaves the last results untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      counter    <= '0;
      partRem    <= '0;
      workQ      <= '0;
      divisorMag <= '0;
      signQ      <= 1'b0;
      signR      <= 1'b0;
      quotient   <= '0;
      remainder  <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              partRem    <= '0;
              workQ      <= dividendAbs;
              divisorMag <= divisorAbs;
              signQ      <= dividendNeg ^ divisorNeg;
              signR      <= dividendNeg;
              counter    <= '0;
`ifdef DIV_EARLY_OUT_EN
              if (earlyOut) begin
                quotient  <= earlyQ;
                remainder <= dividend;
                done      <= 1'b1;
                state     <= DONE;
              end else begin
                state <= CALC;
              end
`else
              state <= CALC;
`endif
            end
          end
          CALC: begin
            partRem <= stepRem;
            workQ   <= finalQ;
            counter <= counter + 1'b1;
            if (counter == LAST_STEP) begin
              quotient  <= signQ ? -finalQ : finalQ;
              remainder <= signR ? -stepRem : stepRem;
              done      <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle integer divider in the EX stage. It consumes the decoded isdiv/signeddiv controls and the EX operands, and produces the quotient for LO and the remainder for HI.
- It raises a stall request to the hazard unit while it computes, and is cancelled on pipeline flush (exception/eret).
- It uses a radix-2 restoring algorithm with sign correction, giving one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/quotient/remainder width in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  divide request. Driven from isdivE & ~flushE and held while the instruction sits in EX.
- signed_div  in  1  1 = signed (div), 0 = unsigned (divu). Sampled with start.
- cancel  in  1  abort the operation in progress (flushE/exception).
- dividend  in  WIDTH  rs value. Sampled when start is accepted.
- divisor  in  WIDTH  rt value. Sampled when start is accepted.
- stall_div  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse; quotient/remainder are valid.
- quotient  out  WIDTH  result written to LO.
- remainder  out  WIDTH  result written to HI.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, working registers=0.
  - quotient=0, remainder=0, done=0, stall_div=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1 and cancel=0, accept the operation:
    - Latch |dividend| and |divisor|. Magnitudes are taken only when signed_div=1 and the MSB is set.
    - Latch sign_q = signed_div & (dividend MSB ^ divisor MSB).
    - Latch sign_r = signed_div & dividend MSB.
    - Clear the partial remainder and set counter=0.
    - Go to CALC.
- CALC, one step per cycle:
  - Shift {partial remainder, dividend register} left by 1.
  - trial = partial remainder − |divisor|, computed at WIDTH+1 bits.
  - If trial is non-negative: partial remainder = trial and quotient LSB = 1; otherwise quotient LSB = 0.
  - counter increments each cycle. After step WIDTH (counter == WIDTH−1 at that edge), go to DONE.
- DONE:
  - quotient = sign_q ? −q : q; remainder = sign_r ? −r : r. Both registered on the transition into DONE.
  - done=1 for exactly this one cycle, then unconditionally return to IDLE.
  - start is ignored in DONE. The same instruction is leaving EX this cycle, so it must not restart.
- stall_div:
  - Combinational: (state==IDLE & start & ~cancel) | state==CALC.
  - It is 0 in DONE, so the pipeline advances on the done cycle.
- Latency: start accepted at cycle 0, CALC in cycles 1..WIDTH, done=1 in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Results persist on quotient/remainder until the next accepted operation completes.
- cancel=1 in any state:
  - Next state is IDLE, no done pulse.
  - quotient/remainder keep their previous values.
  - cancel has priority over start in the same cycle.
- Divide by zero (divisor==0, no trap):
  - The algorithm runs normally.
  - Result: quotient = all ones before sign correction; remainder = |dividend| before sign correction. Sign correction then applies.
  - Unsigned example: 7/0 gives q=0xFFFFFFFF, r=7.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0. This falls out of the WIDTH+1-bit magnitude arithmetic and needs no special case.
- start or operand changes during CALC are ignored; the operands were latched at acceptance.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined, at acceptance in IDLE:
  - If divisor==0 or |dividend| < |divisor|, skip CALC and go directly to DONE.
  - Results: quotient = 0 with remainder = dividend (magnitude case), or the divide-by-zero values above.
  - done is asserted at cycle 1 and stall_div is high only in cycle 0.
- When undefined: every operation takes the full WIDTH CALC cycles; results are identical.

Decomposition:
- Package mips_div_pkg:
  - div_state_t enum (IDLE, CALC, DONE).
  - DIV_WIDTH=32.
  - Counter width localparam $clog2(DIV_WIDTH).
- Sub-module div_step: purely combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
- The FSM, counter and sign correction stay in div_unit.

Test Plan:
- Unsigned 100/7 (signed_div=0): stall_div high cycles 0..32; done at cycle 33; q=14, r=2; stall_div low in the done cycle.
- Signed −7/2 (0xFFFFFFF9 / 2): q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Also signed 7/−2: q=−3, r=1.
- Edge values:
  - Signed 0x80000000/0xFFFFFFFF: q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF/1: q=0xFFFFFFFF, r=0.
  - Divide by zero, unsigned 7/0: q=0xFFFFFFFF, r=7.
- Cancel at cycle 10 of 100/7: state returns to IDLE next cycle; no done pulse; q/r unchanged from the prior result. A new start afterwards completes normally.
- Async reset pulled low mid-CALC (cycle 15, between edges): all outputs clear immediately. After release, start with 9/3 gives q=3, r=0.
- With DIV_EARLY_OUT_EN: 5/9 gives done at cycle 1, q=0, r=5. Without the macro: same result at cycle 33.
